// File: rtl/regfile_wb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_pkg
//   Shared types and default sizes for the register-file write-back queue.
//   wb_entry_t : one queued register write {addr, data} at the default widths
//   wb_src_e   : which producer won arbitration this cycle
// ---------------------------------------------------------------------------
package regfile_wb_pkg;

  localparam int WB_DEPTH    = 4;
  localparam int WB_NUM_REGS = 16;
  localparam int WB_ADDR_W   = 5;
  localparam int WB_DATA_W   = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_fifo.sv
// ---------------------------------------------------------------------------
// regfile_wb_fifo
//   DEPTH-entry synchronous FIFO. The caller guarantees push only when not
//   full and pop only when not empty. All entries and a per-slot valid vector
//   are exported so the parent can build a pending-destination mask.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data at the tail
//   push_data    entry to enqueue
//   pop          drop the head entry
//   head_data    current head entry (meaningful when count != 0)
//   entries      raw storage, indexed by slot
//   entry_valid  bit i = 1 when slot i holds a queued entry
//   count        occupancy 0..DEPTH (authoritative full/empty)
// ---------------------------------------------------------------------------
module regfile_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head_data,
  output logic [DEPTH-1:0][W-1:0]      entries,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  // NOTE: storage is deliberately not reset; entry_valid (derived from the
  // reset count/pointers) masks stale contents, and leaving it unreset lets
  // it map onto plain flops or RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slot i is live when its distance from the head (mod DEPTH) is below count.
  always_comb begin
    logic [PW-1:0] off;
    off         = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PW'(i) - rd_ptr_q;
      entry_valid[i] = ({1'b0, off} < count_q);
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign entries   = mem_q;
  assign count     = count_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// ---------------------------------------------------------------------------
// regfile_writeback_queue
//   Write-side driver of the register file. Accepts ALU and load results over
//   valid/ready (load has priority), queues them in order, and issues at most
//   one registered RF write per cycle. Publishes a pending-destination mask so
//   the controller can stall reads of registers with writes still in flight.
// Optional feature
//   WB_R0_DISCARD_EN : requests to register 0 are handshaken but dropped.
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   alu_valid/ready/addr/data     ALU result request
//   mem_valid/ready/addr/data     load result request (wins arbitration)
//   wb_stall                      hold the queue head, no RF write
//   RegWrite, rd, write_data      registered RF write port
//   pending_mask                  bit r set while a queued/issuing write targets r
//   err_addr                      sticky: an accepted request had addr >= NUM_REGS
//   count                         queue occupancy
// ---------------------------------------------------------------------------
module regfile_writeback_queue
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH    = WB_DEPTH,
  parameter int NUM_REGS = WB_NUM_REGS,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int DATA_W   = WB_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [ADDR_W-1:0]         alu_addr,
  input  logic [DATA_W-1:0]         alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic                      wb_stall,
  output logic                      RegWrite,
  output logic [ADDR_W-1:0]         rd,
  output logic [DATA_W-1:0]         write_data,
  output logic [NUM_REGS-1:0]       pending_mask,
  output logic                      err_addr,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int                CW         = $clog2(DEPTH) + 1;
  localparam int                EW         = ADDR_W + DATA_W;
  localparam logic [CW-1:0]     FULL_CNT   = CW'(DEPTH);
  localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  // One-hot of a destination; illegal addresses match no bit.
  function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (a == ADDR_W'(r)) oh[r] = 1'b1;
    end
    return oh;
  endfunction

  wb_src_e                  src;
  logic                     full, accept, push, pop;
  logic [ADDR_W-1:0]        acc_addr;
  logic [DATA_W-1:0]        acc_data;
  logic [EW-1:0]            head;
  logic [DEPTH-1:0][EW-1:0] entries;
  logic [DEPTH-1:0]         entry_valid;
  logic [CW-1:0]            fifo_count;

  logic                     reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]        rd_q, rd_d;
  logic [DATA_W-1:0]        write_data_q, write_data_d;
  logic                     err_q, err_d;

  // Ready depends only on registered occupancy, so a full queue refuses a
  // push even in a cycle where it also pops.
  always_comb begin
    full      = (fifo_count == FULL_CNT);
    mem_ready = !full;
    alu_ready = !full && !mem_valid;
    src       = mem_valid ? SRC_MEM : SRC_ALU;
    accept    = !full && (mem_valid || alu_valid);
    acc_addr  = (src == SRC_MEM) ? mem_addr : alu_addr;
    acc_data  = (src == SRC_MEM) ? mem_data : alu_data;
`ifdef WB_R0_DISCARD_EN
    push      = accept && (acc_addr != '0);
`else
    push      = accept;
`endif
    pop       = (fifo_count != '0) && !wb_stall;
  end

  regfile_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_data   ({acc_addr, acc_data}),
    .pop         (pop),
    .head_data   (head),
    .entries     (entries),
    .entry_valid (entry_valid),
    .count       (fifo_count)
  );

  // Output stage: a popped head is presented for exactly one cycle; address
  // and data hold when idle.
  always_comb begin
    reg_write_d  = pop;
    rd_d         = rd_q;
    write_data_d = write_data_q;
    if (pop) begin
      rd_d         = head[EW-1:DATA_W];
      write_data_d = head[DATA_W-1:0];
    end
    err_d = err_q || (accept && ({1'b0, acc_addr} >= NUM_REGS_L));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
      err_q        <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
      err_q        <= err_d;
    end
  end

  // Every write not yet captured by the RF: queued entries plus the one
  // currently on the output port.
  always_comb begin
    pending_mask = reg_write_q ? dest_onehot(rd_q) : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending_mask = pending_mask | dest_onehot(entries[i][EW-1:DATA_W]);
    end
  end

  assign RegWrite   = reg_write_q;
  assign rd         = rd_q;
  assign write_data = write_data_q;
  assign err_addr   = err_q;
  assign count      = fifo_count;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback_queue
//   Scoreboard bench: every request the bench expects to be accepted is
//   pushed to a queue; every RF write the DUT issues pops and compares.
//   A small occupancy model predicts ready, RegWrite timing, count and
//   err_addr. Inputs change on the falling edge; outputs are checked on the
//   following falling edge.
// ---------------------------------------------------------------------------
module tb_regfile_writeback_queue;
  import regfile_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int NREGS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0, wb_stall = 1'b0;
  logic [4:0]  alu_addr = '0, mem_addr = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, RegWrite, err_addr;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [15:0] pending_mask;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  wb_entry_t sb[$];
  int        model_cnt = 0;
  logic      model_err = 1'b0;

  regfile_writeback_queue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .wb_stall     (wb_stall),
    .RegWrite     (RegWrite),
    .rd           (rd),
    .write_data   (write_data),
    .pending_mask (pending_mask),
    .err_addr     (err_addr),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Destinations of all writes not yet seen on the RF port.
  function automatic logic [15:0] model_mask();
    logic [15:0] m;
    m = '0;
    foreach (sb[i]) begin
      if (sb[i].addr < 5'(NREGS)) m[sb[i].addr[3:0]] = 1'b1;
    end
    return m;
  endfunction

  // One clock: drive at the falling edge, predict, check at the next one.
  task automatic step(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic st);
    logic      is_full, acc, do_push, do_pop;
    wb_entry_t e;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    wb_stall  = st;
    #1;
    is_full = (model_cnt == DEPTH);
    check("mem_ready", 64'(mem_ready), 64'(!is_full));
    check("alu_ready", 64'(alu_ready), 64'(!is_full && !mv));
    acc     = !is_full && (mv || av);
    do_pop  = (model_cnt > 0) && !st;
    do_push = 1'b0;
    e.addr  = mv ? ma : aa;
    e.data  = mv ? md : ad;
    if (acc) begin
      do_push = 1'b1;
      if (e.addr >= 5'(NREGS)) model_err = 1'b1;
`ifdef WB_R0_DISCARD_EN
      if (e.addr == 5'd0) do_push = 1'b0;
`endif
    end
    if (do_push) sb.push_back(e);
    model_cnt = model_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    @(posedge clk);
    @(negedge clk);
    check("pending_mask", 64'(pending_mask), 64'(model_mask()));
    check("RegWrite", 64'(RegWrite), 64'(do_pop));
    check("count", 64'(count), 64'(model_cnt));
    check("err_addr", 64'(err_addr), 64'(model_err));
    if (RegWrite) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rd", 64'(rd), 64'(e.addr));
        check("write_data", 64'(write_data), 64'(e.data));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic alu_push(input logic [4:0] a, input logic [31:0] d, input logic st);
    step(1'b0, 5'd0, 32'd0, 1'b1, a, d, st);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic apply_reset();
    mem_valid = 1'b0; alu_valid = 1'b0; wb_stall = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_RegWrite", 64'(RegWrite), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_mask", 64'(pending_mask), 64'(0));
    check("rst_err", 64'(err_addr), 64'(0));
    check("rst_rd", 64'(rd), 64'(0));
    check("rst_wdata", 64'(write_data), 64'(0));
    sb.delete();
    model_cnt = 0;
    model_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset state, single ALU write, two-cycle latency
    apply_reset();
    alu_push(5'd3, 32'h00F3_4E5B, 1'b0);
    idle(3);

    // 2: simultaneous requests, load wins, ALU follows next cycle
    step(1'b1, 5'd4, 32'h0001_A45F, 1'b1, 5'd5, 32'd0, 1'b0);
    alu_push(5'd5, 32'd0, 1'b0);
    idle(4);

    // 3: stalled fill, held 5th request, burst drain
    for (int i = 0; i < 4; i++) alu_push(5'(6 + i), 32'hA000_0000 + 32'(i), 1'b1);
    step(1'b1, 5'd11, 32'hDEAD_0005, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(5);

    // 4: full plus pop refuses the push; 9 back-to-back pushes wrap pointers
    for (int i = 0; i < 4; i++) alu_push(5'(1 + i), 32'hB000_0000 + 32'(i), 1'b1);
    alu_push(5'd12, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 5'(i), 32'hC000_0000 + 32'(i), 1'b0, 5'd0, 32'd0, 1'b0);
    idle(6);

    // 5: pending mask follows addr 2; illegal addr sets sticky error
    alu_push(5'd2, 32'h0000_0222, 1'b1);
    check("mask_bit2", 64'(pending_mask[2]), 64'(1));
    idle(3);
    check("mask_bit2_clear", 64'(pending_mask[2]), 64'(0));
    step(1'b1, 5'd20, 32'h0000_0014, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(4);
    check("err_sticky", 64'(err_addr), 64'(1));

    // 6: reset with queued writes and one on the port, then silence
    for (int i = 0; i < 3; i++) alu_push(5'(13 + i), 32'hD000_0000 + 32'(i), 1'b1);
    idle(1);
    apply_reset();
    idle(4);

    // register 0 handling (discarded when the option is built in)
    alu_push(5'd0, 32'h0000_00AA, 1'b0);
    idle(3);

    // randomized traffic including illegal addresses and stalls
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), $urandom,
           ($urandom_range(0, 3) == 0));
    end
    idle(8);
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
